ecc_point_ctrl: RTL and testbench

- Sequencer that computes affine elliptic-curve point addition or doubling on y^2 = x^3 + a*x + b mod p by issuing a fixed schedule of add/sub/mult/div operations to one GFAU instance.
- Sits between the scalar-multiplication loop (requester) and the GFAU. It owns the GFAU operand/opcode bus and holds intermediates in an internal temp register file.
- Treats the GFAU as a black box and performs no representation or domain conversion.

---
 rtl/ecc_pkg.sv | 41 ++++
 rtl/ecc_step_rom.sv | 46 ++++
 rtl/ecc_point_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ecc_point_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types for the elliptic-curve point controller: GFAU opcodes,
// operand selects, controller states and the schedule step record.
package ecc_pkg;

   // GFAU opcodes; OP_DIV computes in_0 * in_1^-1
   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_SUB  = 2'd1;
   localparam logic [1:0] OP_MULT = 2'd2;
   localparam logic [1:0] OP_DIV  = 2'd3;

   // Width of the schedule step counter (longest schedule has 12 steps)
   localparam int PC_W = 4;

   // Operand / destination selects for one schedule step
   typedef enum logic [3:0] {X1, Y1, X2, Y2, A, T0, T1, L, X3, Y3} opnd_e;

   // Controller states
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_e;

   // One schedule step: dst = src_a op src_b
   typedef struct packed {
      logic [1:0] op;
      opnd_e      src_a;
      opnd_e      src_b;
      opnd_e      dst;
      logic       last;
   } step_t;

   function automatic step_t mk_step(input logic [1:0] op, input opnd_e src_a,
                                     input opnd_e src_b, input opnd_e dst,
                                     input logic last);
      step_t s;
      s.op    = op;
      s.src_a = src_a;
      s.src_b = src_b;
      s.dst   = dst;
      s.last  = last;
      return s;
   endfunction

endpackage

// File: rtl/ecc_step_rom.sv
// Step decode: maps (pc, doubling) to the operation the GFAU runs next.
module ecc_step_rom
   import ecc_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  logic            dbl,
   output step_t           step
);

   // Fixed add (9 steps) and double (12 steps) schedules
   always_comb begin
      // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
      step = mk_step(OP_ADD, T0, T0, T0, 1'b1);
      if (dbl) begin
         case (pc)
            4'd0:    step = mk_step(OP_MULT, X1, X1, T0, 1'b0);
            4'd1:    step = mk_step(OP_ADD,  T0, T0, T1, 1'b0);
            4'd2:    step = mk_step(OP_ADD,  T1, T0, T0, 1'b0);
            4'd3:    step = mk_step(OP_ADD,  T0, A,  T0, 1'b0);
            4'd4:    step = mk_step(OP_ADD,  Y1, Y1, T1, 1'b0);
            4'd5:    step = mk_step(OP_DIV,  T0, T1, L,  1'b0);
            4'd6:    step = mk_step(OP_MULT, L,  L,  T0, 1'b0);
            4'd7:    step = mk_step(OP_SUB,  T0, X1, T0, 1'b0);
            4'd8:    step = mk_step(OP_SUB,  T0, X1, X3, 1'b0);
            4'd9:    step = mk_step(OP_SUB,  X1, X3, T1, 1'b0);
            4'd10:   step = mk_step(OP_MULT, L,  T1, T1, 1'b0);
            4'd11:   step = mk_step(OP_SUB,  T1, Y1, Y3, 1'b1);
            default: ;
         endcase
      end else begin
         case (pc)
            4'd0:    step = mk_step(OP_SUB,  Y2, Y1, T0, 1'b0);
            4'd1:    step = mk_step(OP_SUB,  X2, X1, T1, 1'b0);
            4'd2:    step = mk_step(OP_DIV,  T0, T1, L,  1'b0);
            4'd3:    step = mk_step(OP_MULT, L,  L,  T0, 1'b0);
            4'd4:    step = mk_step(OP_SUB,  T0, X1, T0, 1'b0);
            4'd5:    step = mk_step(OP_SUB,  T0, X2, X3, 1'b0);
            4'd6:    step = mk_step(OP_SUB,  X1, X3, T1, 1'b0);
            4'd7:    step = mk_step(OP_MULT, L,  T1, T1, 1'b0);
            4'd8:    step = mk_step(OP_SUB,  T1, Y1, Y3, 1'b1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ecc_point_ctrl.sv
// Affine point add/double sequencer: resolves special cases locally and
// otherwise runs a fixed schedule of field operations on one GFAU.
module ecc_point_ctrl
   import ecc_pkg::*;
#(
   parameter int SIZE    = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            start,
   input  logic            mode,
   input  logic [SIZE-1:0] x1,
   input  logic [SIZE-1:0] y1,
   input  logic [SIZE-1:0] x2,
   input  logic [SIZE-1:0] y2,
   input  logic            inf1,
   input  logic            inf2,
   input  logic [SIZE-1:0] coef_a,
   input  logic [SIZE-1:0] prime,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] x3,
   output logic [SIZE-1:0] y3,
   output logic            inf3,
   output logic            err,
   output logic [SIZE-1:0] gfau_in_0,
   output logic [SIZE-1:0] gfau_in_1,
   output logic [SIZE-1:0] gfau_prime,
   output logic [1:0]      gfau_op,
   output logic            gfau_start,
   input  logic [SIZE-1:0] gfau_result,
   input  logic            gfau_done
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Counter is cleared at ISSUE and counts WAIT cycles; aborting at this value
   // makes the done pulse (after FIN) land exactly TIMEOUT cycles after ISSUE.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 3);

   state_e            state, state_nxt;
   logic [SIZE-1:0]   r_x1, r_y1, r_x2, r_y2, r_a, r_p;
   logic              r_inf1, r_inf2, r_mode, dbl;
   logic [SIZE-1:0]   t0, t1, lam, r_x3, r_y3;
   logic              r_inf3;
   logic [PC_W-1:0]   pc;
   logic [CNT_W-1:0]  tmo_cnt;
   step_t             step;
   logic              chk_special, chk_inf, chk_dbl;
   logic [SIZE-1:0]   chk_x, chk_y;

   ecc_step_rom u_rom (
      .pc   (pc),
      .dbl  (dbl),
      .step (step)
   );

   function automatic logic [SIZE-1:0] opnd(input opnd_e sel);
      case (sel)
         X1:      return r_x1;
         Y1:      return r_y1;
         X2:      return r_x2;
         Y2:      return r_y2;
         A:       return r_a;
         T0:      return t0;
         T1:      return t1;
         L:       return lam;
         X3:      return r_x3;
         Y3:      return r_y3;
         default: return '0;
      endcase
   endfunction

   // Special-case classification of the latched points, in priority order
   always_comb begin
      chk_special = 1'b0;
      chk_inf     = 1'b0;
      chk_dbl     = r_mode;
      chk_x       = r_x1;
      chk_y       = r_y1;
      if (r_inf1) begin
         chk_special = 1'b1;
         if (r_mode) begin
            chk_inf = 1'b1;
         end else begin
            chk_x   = r_x2;
            chk_y   = r_y2;
            chk_inf = r_inf2;
         end
      end else if (!r_mode && r_inf2) begin
         chk_special = 1'b1;
      end else if (!r_mode && (r_x1 == r_x2) && (r_y1 != r_y2)) begin
         chk_special = 1'b1;
         chk_inf     = 1'b1;
         chk_x       = '0;
         chk_y       = '0;
      end else begin
         chk_dbl = r_mode || ((r_x1 == r_x2) && (r_y1 == r_y2));
         if (chk_dbl && (r_y1 == '0)) begin
            chk_special = 1'b1;
            chk_inf     = 1'b1;
            chk_x       = '0;
            chk_y       = '0;
         end
      end
   end

   // GFAU bus: driven from the step decode during ISSUE/WAIT, quiet otherwise
   always_comb begin
      gfau_op    = OP_ADD;
      gfau_in_0  = '0;
      gfau_in_1  = '0;
      gfau_start = 1'b0;
      if (state == S_ISSUE || state == S_WAIT) begin
         gfau_op    = step.op;
         gfau_in_0  = opnd(step.src_a);
         gfau_in_1  = opnd(step.src_b);
         gfau_start = (state == S_ISSUE);
      end
   end

   assign gfau_prime = r_p;

   // State register
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CHECK;
         S_CHECK: state_nxt = chk_special ? S_FIN : S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (gfau_done)                state_nxt = step.last ? S_FIN : S_ISSUE;
            else if (tmo_cnt == TMO_LAST) state_nxt = S_FIN;
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, temp file, step/timeout counters and result outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0; r_a <= '0; r_p <= '0;
         r_inf1 <= 1'b0; r_inf2 <= 1'b0; r_mode <= 1'b0; dbl <= 1'b0;
         t0 <= '0; t1 <= '0; lam <= '0; r_x3 <= '0; r_y3 <= '0; r_inf3 <= 1'b0;
         pc <= '0; tmo_cnt <= '0;
         busy <= 1'b0; done <= 1'b0; err <= 1'b0;
         x3 <= '0; y3 <= '0; inf3 <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  r_x1 <= x1; r_y1 <= y1; r_x2 <= x2; r_y2 <= y2;
                  r_a <= coef_a; r_p <= prime;
                  r_inf1 <= inf1; r_inf2 <= inf2; r_mode <= mode;
                  r_x3 <= '0; r_y3 <= '0; r_inf3 <= 1'b0;
                  busy <= 1'b1;
                  err  <= 1'b0;
               end
            end
            S_CHECK: begin
               dbl    <= chk_dbl;
               pc     <= '0;
               r_x3   <= chk_x;
               r_y3   <= chk_y;
               r_inf3 <= chk_inf;
            end
            S_ISSUE: tmo_cnt <= '0;
            S_WAIT: begin
               if (gfau_done) begin
                  case (step.dst)
                     T0:      t0   <= gfau_result;
                     T1:      t1   <= gfau_result;
                     L:       lam  <= gfau_result;
                     X3:      r_x3 <= gfau_result;
                     Y3:      r_y3 <= gfau_result;
                     default: ;
                  endcase
                  pc <= pc + 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_FIN: begin
               x3   <= r_x3;
               y3   <= r_y3;
               inf3 <= r_inf3;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Self-checking bench for ecc_point_ctrl on y^2 = x^3 + x + 1 mod 23 with a
// behavioural mod-p GFAU of random latency and an affine reference model.
module tb_ecc_point_ctrl;

   localparam int SIZE = 32;
   localparam int TMO  = 16;
   localparam int P    = 23;
   localparam int CA   = 1;

   logic            i_clk = 1'b0;
   logic            i_rst, start, mode, inf1, inf2;
   logic [SIZE-1:0] x1, y1, x2, y2, coef_a, prime;
   logic            busy, done, inf3, err, gfau_start;
   logic [SIZE-1:0] x3, y3, gfau_in_0, gfau_in_1, gfau_prime;
   logic [1:0]      gfau_op;
   logic [SIZE-1:0] gfau_result = '0;
   logic            gfau_done = 1'b0;

   ecc_point_ctrl #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .start(start), .mode(mode),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .inf1(inf1), .inf2(inf2),
      .coef_a(coef_a), .prime(prime), .busy(busy), .done(done),
      .x3(x3), .y3(y3), .inf3(inf3), .err(err),
      .gfau_in_0(gfau_in_0), .gfau_in_1(gfau_in_1), .gfau_prime(gfau_prime),
      .gfau_op(gfau_op), .gfau_start(gfau_start),
      .gfau_result(gfau_result), .gfau_done(gfau_done)
   );

   always #5 i_clk = ~i_clk;

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   int lat_min = 1, lat_max = 13, withhold = -1, op_base = 0;
   int lat_roll = 1;
   int n_starts = 0, lat_sum = 0, issue_cyc = 0, remain = 0, stab_viol = 0;
   logic [SIZE-1:0] pend_res = '0, cap0 = '0, cap1 = '0;
   logic [1:0]      cap_op = '0;
   int px[$], py[$];

   always @(posedge i_clk) cyc <= cyc + 1;
   always @(negedge i_clk) lat_roll <= $urandom_range(lat_max, lat_min);

   function automatic longint md(input longint v);
      return ((v % P) + P) % P;
   endfunction

   function automatic longint inv(input longint v);
      longint r = 0;
      for (int i = 1; i < P; i++) if (md(v * i) == 1) r = i;
      return r;
   endfunction

   function automatic longint gf(input logic [1:0] op, input longint a, input longint b);
      case (op)
         2'd0:    return md(a + b);
         2'd1:    return md(a - b);
         2'd2:    return md(a * b);
         default: return md(a * inv(b));
      endcase
   endfunction

   // Behavioural GFAU: result after lat_roll cycles; optionally never answers one step
   always @(posedge i_clk) begin
      if (i_rst) begin
         gfau_done <= 1'b0;
         remain    <= 0;
      end else begin
         gfau_done <= 1'b0;
         if (remain > 0 && (gfau_in_0 !== cap0 || gfau_in_1 !== cap1 || gfau_op !== cap_op))
            stab_viol <= stab_viol + 1;
         if (gfau_start) begin
            n_starts  <= n_starts + 1;
            issue_cyc <= cyc;
            cap0 <= gfau_in_0; cap1 <= gfau_in_1; cap_op <= gfau_op;
            if (n_starts - op_base != withhold) begin
               lat_sum <= lat_sum + lat_roll;
               if (lat_roll == 1) begin
                  gfau_done   <= 1'b1;
                  gfau_result <= SIZE'(gf(gfau_op, gfau_in_0, gfau_in_1));
               end else begin
                  remain   <= lat_roll - 1;
                  pend_res <= SIZE'(gf(gfau_op, gfau_in_0, gfau_in_1));
               end
            end
         end else if (remain > 0) begin
            if (remain == 1) begin
               gfau_done   <= 1'b1;
               gfau_result <= pend_res;
            end
            remain <= remain - 1;
         end
      end
   end

   // Affine reference: special cases first, then the textbook chord/tangent formulas
   task automatic ref_ecc(input logic m, input int ax, ay, input logic ai,
                          input int bx, by, input logic bi,
                          output int ex, ey, output logic ei, output int eops);
      longint lam;
      logic   dbl;
      ex = ax; ey = ay; ei = 1'b0; eops = 0;
      if (ai) begin
         if (m) ei = 1'b1;
         else begin ex = bx; ey = by; ei = bi; end
      end else if (!m && bi) begin
         ei = 1'b0;
      end else if (!m && ax == bx && ay != by) begin
         ei = 1'b1;
      end else begin
         dbl = m || (ax == bx && ay == by);
         if (dbl && ay == 0) ei = 1'b1;
         else begin
            if (dbl) lam = md(md(3 * ax * ax + CA) * inv(md(2 * ay)));
            else     lam = md(md(by - ay) * inv(md(bx - ax)));
            ex   = int'(md(lam * lam - ax - (dbl ? ax : bx)));
            ey   = int'(md(lam * (ax - ex) - ay));
            eops = dbl ? 12 : 9;
         end
      end
   endtask

   // Start one operation and wait (bounded) for done; report latency and GFAU ops
   task automatic run_op(input logic m, input int ax, ay, input logic ai,
                         input int bx, by, input logic bi,
                         output int lat, output int ops, output int lsum, output logic ok);
      int t0, sbase, lbase;
      @(negedge i_clk);
      mode = m; x1 = ax; y1 = ay; inf1 = ai; x2 = bx; y2 = by; inf2 = bi;
      coef_a = CA; prime = P;
      op_base = n_starts; sbase = n_starts; lbase = lat_sum; t0 = cyc;
      start = 1'b1;
      @(negedge i_clk);
      start = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done) begin ok = 1'b1; break; end
         @(negedge i_clk);
      end
      lat = cyc - t0; ops = n_starts - sbase; lsum = lat_sum - lbase;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL done_timeout: no done within bound (got 0, want 1)");
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; start = 1'b0; mode = 0; inf1 = 0; inf2 = 0;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0; coef_a = '0; prime = '0;
      repeat (3) @(negedge i_clk);
      vectors++;
      if ({busy, done, inf3, err, gfau_start} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 00000", {busy, done, inf3, err, gfau_start});
      end
      vectors++;
      if ({x3, y3, gfau_in_0, gfau_in_1, gfau_prime, gfau_op} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got x3=%0d y3=%0d in0=%0d op=%0d want 0", x3, y3, gfau_in_0, gfau_op);
      end
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_add();
      int lat, ops, lsum; logic ok;
      run_op(1'b0, 3, 10, 1'b0, 9, 7, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({x3, y3, inf3, err} !== {32'd17, 32'd20, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL add_result: got (%0d,%0d,inf=%0d,err=%0d) want (17,20,0,0)", x3, y3, inf3, err);
      end
      vectors++;
      if (ops !== 9) begin
         miscompares++;
         $display("FAIL add_ops: got %0d want 9", ops);
      end
      vectors++;
      if (lat !== 3 + ops + lsum) begin
         miscompares++;
         $display("FAIL add_latency: got %0d want %0d", lat, 3 + ops + lsum);
      end
      vectors++;
      if (gfau_prime !== P) begin
         miscompares++;
         $display("FAIL add_prime: got %0d want %0d", gfau_prime, P);
      end
      @(negedge i_clk);
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL done_pulse: got done,busy=%b want 00", {done, busy});
      end
   endtask

   task automatic test_double();
      int lat, ops, lsum; logic ok;
      for (int k = 0; k < 2; k++) begin
         // k=0: explicit double; k=1: add of equal points promoted to double
         run_op(k == 0, 3, 10, 1'b0, 3, 10, 1'b0, lat, ops, lsum, ok);
         vectors++;
         if ({x3, y3, inf3, err} !== {32'd7, 32'd12, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL dbl_result[%0d]: got (%0d,%0d,inf=%0d,err=%0d) want (7,12,0,0)", k, x3, y3, inf3, err);
         end
         vectors++;
         if (ops !== 12) begin
            miscompares++;
            $display("FAIL dbl_ops[%0d]: got %0d want 12", k, ops);
         end
      end
   endtask

   task automatic test_special();
      int lat, ops, lsum; logic ok;
      run_op(1'b0, 0, 0, 1'b1, 9, 7, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({x3, y3, inf3, ops, lat} !== {32'd9, 32'd7, 1'b0, 32'd0, 32'd3}) begin
         miscompares++;
         $display("FAIL sp_inf1: got (%0d,%0d,inf=%0d) ops=%0d lat=%0d want (9,7,0) ops=0 lat=3", x3, y3, inf3, ops, lat);
      end
      run_op(1'b0, 3, 10, 1'b0, 3, 13, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({inf3, ops, lat} !== {1'b1, 32'd0, 32'd3}) begin
         miscompares++;
         $display("FAIL sp_negation: got inf=%0d ops=%0d lat=%0d want inf=1 ops=0 lat=3", inf3, ops, lat);
      end
      run_op(1'b1, 4, 0, 1'b0, 0, 0, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({inf3, ops} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL sp_dbl_y0: got inf=%0d ops=%0d want inf=1 ops=0", inf3, ops);
      end
   endtask

   task automatic test_timeout();
      int lat, ops, lsum, t_done; logic ok;
      withhold = 2;
      run_op(1'b0, 3, 10, 1'b0, 9, 7, 1'b0, lat, ops, lsum, ok);
      t_done = cyc;
      withhold = -1;
      vectors++;
      if ({err, ops} !== {1'b1, 32'd3}) begin
         miscompares++;
         $display("FAIL tmo_err: got err=%0d ops=%0d want err=1 ops=3", err, ops);
      end
      vectors++;
      if (t_done - issue_cyc !== TMO) begin
         miscompares++;
         $display("FAIL tmo_cycles: got %0d want %0d", t_done - issue_cyc, TMO);
      end
      run_op(1'b0, 3, 10, 1'b0, 9, 7, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({x3, y3, inf3, err} !== {32'd17, 32'd20, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL tmo_recover: got (%0d,%0d,inf=%0d,err=%0d) want (17,20,0,0)", x3, y3, inf3, err);
      end
   endtask

   task automatic test_back_to_back();
      int n_done = 0;
      @(negedge i_clk);
      mode = 0; x1 = 3; y1 = 10; x2 = 9; y2 = 7; inf1 = 0; inf2 = 0; coef_a = CA; prime = P;
      start = 1'b1;
      @(negedge i_clk);
      x1 = 5; y1 = 4; mode = 1;   // second request while busy
      @(negedge i_clk);
      start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done) n_done++;
         @(negedge i_clk);
      end
      vectors++;
      if (n_done !== 1) begin
         miscompares++;
         $display("FAIL b2b_done_count: got %0d want 1", n_done);
      end
      vectors++;
      if ({x3, y3, inf3} !== {32'd17, 32'd20, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_result: got (%0d,%0d,inf=%0d) want (17,20,0)", x3, y3, inf3);
      end
   endtask

   task automatic test_reset_mid();
      int n_done = 0, lat, ops, lsum; logic ok;
      lat_min = 12; lat_max = 12;
      @(negedge i_clk);
      mode = 0; x1 = 3; y1 = 10; x2 = 9; y2 = 7; inf1 = 0; inf2 = 0;
      start = 1'b1;
      @(negedge i_clk);
      start = 1'b0;
      repeat (4) @(negedge i_clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_busy_before: got %0d want 1", busy);
      end
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done || busy) n_done++;
         @(negedge i_clk);
      end
      vectors++;
      if (n_done !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_quiet: got %0d busy/done cycles want 0", n_done);
      end
      lat_min = 1; lat_max = 13;
      repeat (2) @(negedge i_clk);
      run_op(1'b1, 3, 10, 1'b0, 0, 0, 1'b0, lat, ops, lsum, ok);
      vectors++;
      if ({x3, y3, inf3, err} !== {32'd7, 32'd12, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_mid_recover: got (%0d,%0d,inf=%0d,err=%0d) want (7,12,0,0)", x3, y3, inf3, err);
      end
   endtask

   task automatic test_random();
      int lat, ops, lsum, ia, ib, bx, by, ex, ey, eops; logic ok, m, ai, bi, ei;
      for (int n = 0; n < 30; n++) begin
         ia = $urandom_range(px.size() - 1);
         ib = $urandom_range(px.size() - 1);
         bx = px[ib]; by = py[ib];
         case ($urandom_range(3))
            0:       begin bx = px[ia]; by = py[ia]; end
            1:       begin bx = px[ia]; by = int'(md(-py[ia])); end
            default: ;
         endcase
         m  = 1'($urandom_range(1));
         ai = ($urandom_range(7) == 0);
         bi = ($urandom_range(7) == 0);
         ref_ecc(m, px[ia], py[ia], ai, bx, by, bi, ex, ey, ei, eops);
         run_op(m, px[ia], py[ia], ai, bx, by, bi, lat, ops, lsum, ok);
         vectors++;
         if (inf3 !== ei || err !== 1'b0 || (!ei && (x3 !== ex || y3 !== ey))) begin
            miscompares++;
            $display("FAIL rnd_result[%0d]: got (%0d,%0d,inf=%0d,err=%0d) want (%0d,%0d,inf=%0d,err=0)",
                     n, x3, y3, inf3, err, ex, ey, ei);
         end
         vectors++;
         if (ops !== eops || lat !== 3 + eops + lsum) begin
            miscompares++;
            $display("FAIL rnd_timing[%0d]: got ops=%0d lat=%0d want ops=%0d lat=%0d",
                     n, ops, lat, eops, 3 + eops + lsum);
         end
      end
      vectors++;
      if (stab_viol !== 0) begin
         miscompares++;
         $display("FAIL operand_stability: got %0d changes during WAIT want 0", stab_viol);
      end
   endtask

   initial begin
      for (int x = 0; x < P; x++)
         for (int y = 0; y < P; y++)
            if (md(y * y) == md(x * x * x + CA * x + 1)) begin
               px.push_back(x);
               py.push_back(y);
            end
      test_reset();
      test_add();
      test_double();
      test_special();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
